// File: rtl/alu_pkg.sv
// Shared opcode encoding, FSM state encoding and default datapath width
// for the multi-cycle ALU.
package alu_pkg;

   localparam int ALU_WIDTH_DEFAULT = 8;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_XOR = 4'd4,
      OP_NOT = 4'd5,
      OP_SHL = 4'd6,
      OP_SAR = 4'd7,
      OP_ADC = 4'd8,
      OP_SBB = 4'd9,
      OP_MUL = 4'd10,
      OP_ROL = 4'd11,
      OP_ROR = 4'd12,
      OP_SHR = 4'd13
   } opcode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_e;

endpackage

// File: rtl/alu_mc_if.sv
// Request/result bundle of the ALU: master drives operations, slave (the ALU)
// returns results and flags.
interface alu_mc_if
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH_DEFAULT
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       opcode;
   logic             out_valid;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             carry;
   logic             zero;
   logic             negative;
   logic             overflow;

   modport master (
      output in_valid, a, b, opcode,
      input  in_ready, out_valid, result, result_hi, carry, zero, negative, overflow
   );

   modport slave (
      input  in_valid, a, b, opcode,
      output in_ready, out_valid, result, result_hi, carry, zero, negative, overflow
   );

endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: operands load on start, one partial product
// is added per cycle, and done/product present the final step combinationally.
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH);

   logic               busy_q,   busy_d;
   logic [CW-1:0]      cnt_q,    cnt_d;
   logic [2*WIDTH-1:0] mcand_q,  mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q,    acc_d;
   logic [2*WIDTH-1:0] step_acc_s;

   // The last step's sum is handed out directly so the owner can register it on that edge.
   assign step_acc_s = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
   assign done       = busy_q && (cnt_q == CW'(WIDTH - 1));
   assign product    = step_acc_s;

   // Load, step and finish control of the shift-add sequence.
   always_comb begin
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      if (start) begin
         busy_d   = 1'b1;
         cnt_d    = {CW{1'b0}};
         mcand_d  = {{WIDTH{1'b0}}, a};
         mplier_d = b;
         acc_d    = {(2*WIDTH){1'b0}};
      end else if (busy_q) begin
         acc_d    = step_acc_s;
         mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
         mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
         cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
         busy_d   = !done;
      end else begin
         busy_d   = 1'b0;
      end
   end

   // Sequencer registers; reset aborts any product in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q   <= 1'b0;
         cnt_q    <= {CW{1'b0}};
         mcand_q  <= {(2*WIDTH){1'b0}};
         mplier_q <= {WIDTH{1'b0}};
         acc_q    <= {(2*WIDTH){1'b0}};
      end else begin
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops with registered
// results and flags, plus a WIDTH-cycle sequential unsigned multiply.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
   input  logic     clk,
   input  logic     rst,
   alu_mc_if.slave  bus
);

   localparam int W = WIDTH;

   state_e         state_q, state_d;
   logic [W-1:0]   result_q, result_d;
   logic [W-1:0]   result_hi_q, result_hi_d;
   logic           carry_q, carry_d;
   logic           zero_q, zero_d;
   logic           negative_q, negative_d;
   logic           overflow_q, overflow_d;
   logic           out_valid_q, out_valid_d;

   logic           accept_s;
   logic           mul_start_s;
   logic           mul_done_s;
   logic [2*W-1:0] mul_product_s;
   logic [W:0]     sum_s;
   logic [W:0]     diff_s;
   logic [W-1:0]   alu_res_s;
   logic           alu_carry_s;
   logic           alu_ovf_s;

   assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
   assign accept_s      = bus.in_valid && bus.in_ready;

   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.result_hi = result_hi_q;
   assign bus.carry     = carry_q;
   assign bus.zero      = zero_q;
   assign bus.negative  = negative_q;
   assign bus.overflow  = overflow_q;

   alu_mul_seq #(.WIDTH(W)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start_s),
      .a       (bus.a),
      .b       (bus.b),
      .done    (mul_done_s),
      .product (mul_product_s)
   );

   // Single-cycle datapath; ADC/SBB fold in the carry flag held before this accept.
   always_comb begin
      sum_s  = {1'b0, bus.a} + {1'b0, bus.b}
             + {{W{1'b0}}, (bus.opcode == OP_ADC) & carry_q};
      diff_s = {1'b0, bus.a} - {1'b0, bus.b}
             - {{W{1'b0}}, (bus.opcode == OP_SBB) & carry_q};
      alu_res_s   = {W{1'b0}};
      alu_carry_s = 1'b0;
      alu_ovf_s   = 1'b0;
      case (bus.opcode)
         OP_ADD, OP_ADC: begin
            alu_res_s   = sum_s[W-1:0];
            alu_carry_s = sum_s[W];
            alu_ovf_s   = (bus.a[W-1] == bus.b[W-1]) && (sum_s[W-1] != bus.a[W-1]);
         end
         OP_SUB, OP_SBB: begin
            alu_res_s   = diff_s[W-1:0];
            alu_carry_s = diff_s[W];
            alu_ovf_s   = (bus.a[W-1] != bus.b[W-1]) && (diff_s[W-1] != bus.a[W-1]);
         end
         OP_AND: alu_res_s = bus.a & bus.b;
         OP_OR:  alu_res_s = bus.a | bus.b;
         OP_XOR: alu_res_s = bus.a ^ bus.b;
         OP_NOT: alu_res_s = ~bus.a;
         OP_SHL: begin
            alu_res_s   = {bus.a[W-2:0], 1'b0};
            alu_carry_s = bus.a[W-1];
            alu_ovf_s   = bus.a[W-1] ^ bus.a[W-2];
         end
         OP_SAR: begin
            alu_res_s   = {bus.a[W-1], bus.a[W-1:1]};
            alu_carry_s = bus.a[0];
         end
         OP_ROL: begin
            alu_res_s   = {bus.a[W-2:0], bus.a[W-1]};
            alu_carry_s = bus.a[W-1];
         end
         OP_ROR: begin
            alu_res_s   = {bus.a[0], bus.a[W-1:1]};
            alu_carry_s = bus.a[0];
         end
         OP_SHR: begin
            alu_res_s   = {1'b0, bus.a[W-1:1]};
            alu_carry_s = bus.a[0];
         end
         default: alu_res_s = {W{1'b0}};
      endcase
   end

   // FSM next state and output/flag updates at accept or multiply completion.
   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      carry_d     = carry_q;
      zero_d      = zero_q;
      negative_d  = negative_q;
      overflow_d  = overflow_q;
      out_valid_d = 1'b0;
      mul_start_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_s && (bus.opcode == OP_MUL)) begin
               state_d     = ST_MUL;
               mul_start_s = 1'b1;
            end else if (accept_s) begin
               result_d    = alu_res_s;
               result_hi_d = {W{1'b0}};
               carry_d     = alu_carry_s;
               zero_d      = (alu_res_s == {W{1'b0}});
               negative_d  = alu_res_s[W-1];
               overflow_d  = alu_ovf_s;
               out_valid_d = 1'b1;
            end else begin
               state_d     = ST_IDLE;
            end
         end
         ST_MUL: begin
            if (mul_done_s) begin
               result_d    = mul_product_s[W-1:0];
               result_hi_d = mul_product_s[2*W-1:W];
               carry_d     = (mul_product_s[2*W-1:W] != {W{1'b0}});
               zero_d      = (mul_product_s == {(2*W){1'b0}});
               negative_d  = mul_product_s[W-1];
               overflow_d  = 1'b0;
               out_valid_d = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               state_d     = ST_MUL;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, result and flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         result_q    <= {W{1'b0}};
         result_hi_q <= {W{1'b0}};
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         negative_q  <= 1'b0;
         overflow_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         carry_q     <= carry_d;
         zero_q      <= zero_d;
         negative_q  <= negative_d;
         overflow_q  <= overflow_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH = 8): directed corner cases plus
// randomized operations compared against an arithmetic reference model.
module tb_alu_mc;

   typedef struct packed {
      logic       ov;
      logic [7:0] res;
      logic [7:0] hi;
      logic       c;
      logic       z;
      logic       n;
      logic       v;
   } obs_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   logic mc;
   obs_t last;

   alu_mc_if #(.WIDTH(8)) bus ();

   alu_mc #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic obs_t observe();
      return {bus.out_valid, bus.result, bus.result_hi, bus.carry, bus.zero, bus.negative, bus.overflow};
   endfunction

   // Reference: results computed from integer arithmetic on the operand values.
   function automatic obs_t model(input logic [3:0] op, input logic [7:0] a,
                                  input logic [7:0] b, input logic cin);
      obs_t e;
      int ua, ub, sa, sb, r, sr, ci;
      ua = int'(a);
      ub = int'(b);
      ci = (op == 4'd8 || op == 4'd9) ? int'(cin) : 0;
      sa = (ua >= 128) ? ua - 256 : ua;
      sb = (ub >= 128) ? ub - 256 : ub;
      e = '0;
      e.ov = 1'b1;
      r = 0;
      sr = 0;
      case (op)
         4'd0, 4'd8: begin
            r = ua + ub + ci; sr = sa + sb + ci;
            e.c = (r > 255); e.v = (sr > 127) || (sr < -128);
         end
         4'd1, 4'd9: begin
            r = ua - ub - ci; sr = sa - sb - ci;
            e.c = (r < 0); e.v = (sr > 127) || (sr < -128);
         end
         4'd2:  r = int'(a & b);
         4'd3:  r = int'(a | b);
         4'd4:  r = int'(a ^ b);
         4'd5:  r = 255 - ua;
         4'd6:  begin r = ua * 2; e.c = (ua >= 128); e.v = (ua >= 128) != ((ua % 128) >= 64); end
         4'd7:  begin r = ua / 2 + ((ua >= 128) ? 128 : 0); e.c = (ua % 2) == 1; end
         4'd10: begin r = ua * ub; e.hi = 8'(r / 256); e.c = (r >= 256); end
         4'd11: begin r = ua * 2 + ua / 128; e.c = (ua >= 128); end
         4'd12: begin r = ua / 2 + (ua % 2) * 128; e.c = (ua % 2) == 1; end
         4'd13: begin r = ua / 2; e.c = (ua % 2) == 1; end
         default: r = 0;
      endcase
      e.res = 8'(r);
      e.z = (op == 4'd10) ? (r == 0) : (e.res == 8'h00);
      e.n = e.res[7];
      return e;
   endfunction

   task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.opcode   = op;
      bus.a        = a;
      bus.b        = b;
   endtask

   task automatic go_idle();
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      obs_t o;
      rst = 1'b1;
      bus.in_valid = 1'b1;
      bus.opcode = 4'd0;
      bus.a = 8'h12;
      bus.b = 8'h34;
      repeat (3) @(posedge clk);
      #1;
      o = observe();
      checks++;
      if (o !== obs_t'(0)) begin
         failures++; $display("FAIL reset_outputs got=%h exp=%h", o, obs_t'(0));
      end
      checks++;
      if (bus.in_ready !== 1'b0) begin
         failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++; $display("FAIL release_in_ready got=%b exp=1", bus.in_ready);
      end
      mc = 1'b0;
      last = '0;
   endtask

   task automatic test_add_sub();
      obs_t o;
      obs_t exp_tab [6];
      logic [3:0] op_tab [6];
      logic [7:0] a_tab [6];
      logic [7:0] b_tab [6];
      op_tab = '{4'd0, 4'd0, 4'd8, 4'd1, 4'd9, 4'd2};
      a_tab  = '{8'h7F, 8'hFF, 8'h00, 8'h00, 8'h05, 8'hF0};
      b_tab  = '{8'h01, 8'h01, 8'h00, 8'h01, 8'h01, 8'h3C};
      exp_tab[0] = '{1'b1, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
      exp_tab[1] = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
      exp_tab[2] = '{1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      exp_tab[3] = '{1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
      exp_tab[4] = '{1'b1, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      exp_tab[5] = '{1'b1, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         drive(op_tab[i], a_tab[i], b_tab[i]);
         @(posedge clk);
         #1;
         o = observe();
         checks++;
         if (o !== exp_tab[i]) begin
            failures++; $display("FAIL add_sub_%0d got=%h exp=%h", i, o, exp_tab[i]);
         end
      end
      go_idle();
      @(posedge clk);
      #1;
      o = observe();
      last = exp_tab[5];
      last.ov = 1'b0;
      checks++;
      if (o !== last) begin
         failures++; $display("FAIL add_sub_hold got=%h exp=%h", o, last);
      end
      mc = 1'b0;
   endtask

   task automatic test_shifts();
      obs_t o;
      obs_t exp_tab [4];
      logic [3:0] op_tab [4];
      logic [7:0] a_tab [4];
      op_tab = '{4'd7, 4'd13, 4'd12, 4'd6};
      a_tab  = '{8'h81, 8'h81, 8'h01, 8'h40};
      exp_tab[0] = '{1'b1, 8'hC0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
      exp_tab[1] = '{1'b1, 8'h40, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
      exp_tab[2] = '{1'b1, 8'h80, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
      exp_tab[3] = '{1'b1, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
         drive(op_tab[i], a_tab[i], 8'h5A);
         @(posedge clk);
         #1;
         o = observe();
         checks++;
         if (o !== exp_tab[i]) begin
            failures++; $display("FAIL shift_%0d got=%h exp=%h", i, o, exp_tab[i]);
         end
      end
      go_idle();
      last = exp_tab[3];
      last.ov = 1'b0;
      mc = 1'b0;
   endtask

   task automatic test_mul();
      obs_t o;
      obs_t exp_mul;
      int bad;
      exp_mul = '{1'b1, 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0};
      drive(4'd10, 8'hFF, 8'hFF);
      @(posedge clk);
      #1;
      bad = 0;
      for (int k = 0; k < 8; k++) begin
         o = observe();
         if (bus.in_ready !== 1'b0 || o !== last) bad++;
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.opcode = 4'd0;
         bus.a = 8'h01;
         bus.b = 8'h01;
         @(posedge clk);
         #1;
      end
      checks++;
      if (bad != 0) begin
         failures++; $display("FAIL mul_busy_window got=%0d_bad_cycles exp=0", bad);
      end
      o = observe();
      checks++;
      if (o !== exp_mul) begin
         failures++; $display("FAIL mul_ff_ff got=%h exp=%h", o, exp_mul);
      end
      go_idle();
      @(posedge clk);
      #1;
      o = observe();
      last = exp_mul;
      last.ov = 1'b0;
      checks++;
      if (o !== last) begin
         failures++; $display("FAIL mul_ignored_input got=%h exp=%h", o, last);
      end
      mc = 1'b1;
   endtask

   task automatic test_random();
      obs_t o;
      obs_t e;
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      for (int i = 0; i < 150; i++) begin
         op = 4'($urandom_range(0, 15));
         a = 8'($urandom);
         b = 8'($urandom);
         if (i % 10 == 0) b = 8'h00;
         e = model(op, a, b, mc);
         drive(op, a, b);
         @(posedge clk);
         #1;
         if (op == 4'd10) begin
            for (int k = 0; k < 8; k++) begin
               o = observe();
               checks++;
               if (o !== last || bus.in_ready !== 1'b0) begin
                  failures++; $display("FAIL rand_mul_wait_%0d got=%h exp=%h rdy=%b", i, o, last, bus.in_ready);
               end
               @(negedge clk);
               bus.in_valid = 1'($urandom);
               bus.opcode = 4'($urandom);
               bus.a = 8'($urandom);
               bus.b = 8'($urandom);
               @(posedge clk);
               #1;
            end
         end
         o = observe();
         checks++;
         if (o !== e) begin
            failures++; $display("FAIL rand_op_%0d op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, o, e);
         end
         mc = e.c;
         last = e;
         last.ov = 1'b0;
         if ($urandom_range(0, 3) == 0) begin
            go_idle();
            @(posedge clk);
            #1;
            o = observe();
            checks++;
            if (o !== last) begin
               failures++; $display("FAIL rand_idle_%0d got=%h exp=%h", i, o, last);
            end
         end
      end
      go_idle();
   endtask

   task automatic test_reset_mid_mul();
      obs_t o;
      int pulses;
      drive(4'd10, 8'h0F, 8'h0F);
      @(posedge clk);
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      o = observe();
      checks++;
      if (o !== obs_t'(0) || bus.in_ready !== 1'b0) begin
         failures++; $display("FAIL mid_mul_reset got=%h rdy=%b exp=%h rdy=0", o, bus.in_ready, obs_t'(0));
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++; $display("FAIL mid_mul_release_ready got=%b exp=1", bus.in_ready);
      end
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid !== 1'b0) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         failures++; $display("FAIL mid_mul_no_result got=%0d_pulses exp=0", pulses);
      end
      drive(4'd8, 8'h00, 8'h00);
      @(posedge clk);
      #1;
      o = observe();
      checks++;
      if (o !== obs_t'({1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0})) begin
         failures++; $display("FAIL mid_mul_carry_cleared got=%h exp=%h", o,
                              obs_t'({1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}));
      end
      go_idle();
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.opcode = 4'd0;
      bus.a = 8'h00;
      bus.b = 8'h00;
      mc = 1'b0;
      last = '0;
      test_reset();
      test_add_sub();
      test_shifts();
      test_mul();
      test_random();
      test_reset_mid_mul();
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width in bits, SHALL be >= 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  operation request.
REQ-005 in_ready  output  1  block can accept an operation this cycle.
REQ-006 a, b  input  WIDTH each  operands.
REQ-007 opcode  input  4  operation select, encoding per REQ-012.
REQ-008 out_valid  output  1  one-cycle pulse: result and flags updated this cycle.
REQ-009 result  output  WIDTH  result, low half for MUL.
REQ-010 result_hi  output  WIDTH  MUL upper half; 0 for all other ops.
REQ-011 carry, zero, negative, overflow  output  1 each  registered flags; hold value between operations.

Function
REQ-012 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SHL a, 7 SAR a (sign-preserving), 8 ADC, 9 SBB, 10 MUL unsigned, 11 ROL a, 12 ROR a, 13 SHR a (logical); 14-15 reserved.
REQ-013 Accept = in_valid && in_ready on a rising edge; operands and opcode are captured at accept.
REQ-014 FSM states IDLE, MUL; in_ready = (state == IDLE) && !rst.
REQ-015 Single-cycle ops: outputs registered at accept edge; out_valid high for the following cycle; back-to-back accepts give one result per cycle.
REQ-016 MUL: IDLE->MUL at accept; one shift-add step per cycle for WIDTH cycles; result registered and out_valid pulsed at accept edge + WIDTH; MUL->IDLE on that edge; in_ready low throughout MUL.
REQ-017 ADD/ADC: {carry,result} = a + b (+ carry flag for ADC); overflow = signed overflow.
REQ-018 SUB/SBB: result = a - b (- carry flag for SBB) mod 2^WIDTH; carry = borrow out; overflow = signed overflow.
REQ-019 ADC/SBB SHALL use the carry flag value held before accept.
REQ-020 Logic ops and NOT: carry = 0, overflow = 0.
REQ-021 SHL/ROL: carry = a[WIDTH-1]; SAR/SHR/ROR: carry = a[0]; SHL overflow = a[WIDTH-1] ^ a[WIDTH-2], other shifts/rotates overflow = 0.
REQ-022 MUL: {result_hi,result} = a * b; carry = (result_hi != 0); overflow = 0; zero = (full product == 0).
REQ-023 All ops except MUL: zero = (result == 0); negative = result[WIDTH-1] for all ops.
REQ-024 Reserved opcodes: result 0, result_hi 0, zero 1, carry/negative/overflow 0, latency as single-cycle op.
REQ-025 in_valid while in_ready low SHALL be ignored with no side effects.
REQ-026 Outputs and flags SHALL change only at accept edges (single-cycle) or MUL completion edge.

Reset
REQ-027 While rst high: state IDLE, result 0, result_hi 0, all flags 0, out_valid 0, in_ready 0.
REQ-028 rst asserted mid-MUL aborts immediately; no out_valid for the aborted op.
REQ-029 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-030 Package alu_pkg SHALL hold the opcode enum, FSM state enum and the default WIDTH constant.
REQ-031 Sub-module alu_mul_seq (parametrised WIDTH, start/done, shift-add) SHALL implement MUL; all other ops in alu_mc.

Verification (WIDTH = 8)
REQ-032 ADD 0x7F+0x01 -> result 0x80, overflow 1, negative 1, carry 0, zero 0, out_valid 1 cycle after accept.
REQ-033 ADD 0xFF+0x01 -> 0x00, carry 1, zero 1; next-cycle ADC 0x00+0x00 -> 0x01, carry 0.
REQ-034 SUB 0x00-0x01 -> 0xFF, carry 1, negative 1; then SBB 0x05-0x01 -> 0x03, carry 0.
REQ-035 MUL 0xFF*0xFF -> result 0x01, result_hi 0xFE, carry 1; out_valid exactly 8 cycles after accept; in_ready low 8 cycles; in_valid during MUL ignored.
REQ-036 SAR 0x81 -> 0xC0 carry 1; SHR 0x81 -> 0x40 carry 1; ROR 0x01 -> 0x80 carry 1; SHL 0x40 -> 0x80 overflow 1.
REQ-037 rst asserted in MUL cycle 4 -> all outputs 0 immediately, no out_valid, in_ready 1 in first cycle after release.
